// File: rtl/mem_sort_master.sv
// In-place signed bubble sort over a word-addressed data memory with combinational reads.
// Define SORT_EARLY_EXIT_EN to finish as soon as a full pass performs no swap.
module mem_sort_master #(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base,
  input  logic [10:0] len,
  output logic        busy,
  output logic        done,
  output logic [31:0] swap_cnt,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] addr,
  output logic [31:0] din,
  input  logic [31:0] read_data
);

  localparam logic [10:0] LP_MAX_LEN = 11'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CMP, S_WR_A, S_WR_B, S_NEXT, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_base;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [10:0] r_i;
  logic [10:0] r_lim;
  logic [31:0] r_swap_cnt;

  logic [10:0] w_len_clamped;
  logic [10:0] w_i_inc;
  logic [10:0] w_lim_dec;
  logic        w_gt;
  logic        w_end_pass;
  logic        w_early_exit;

  assign w_len_clamped = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;
  assign w_i_inc       = r_i + 11'd1;
  assign w_lim_dec     = r_lim - 11'd1;
  assign w_gt          = $signed(r_a) > $signed(r_b);
  assign w_end_pass    = !(w_i_inc < r_lim);
  assign swap_cnt      = r_swap_cnt;

`ifdef SORT_EARLY_EXIT_EN
  logic r_pass_swapped;
  assign w_early_exit = !r_pass_swapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_swapped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_pass_swapped <= 1'b0;
        S_CMP:   if (w_gt) r_pass_swapped <= 1'b1;
        S_NEXT:  if (w_end_pass) r_pass_swapped <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign w_early_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr        = 32'd0;
    din         = 32'd0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (w_len_clamped >= 11'd2) ? S_RD_A : S_DONE;
      end
      S_RD_A: begin
        mem_read    = 1'b1;
        addr        = r_base + {21'd0, r_i};
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        mem_read    = 1'b1;
        addr        = r_base + {21'd0, w_i_inc};
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        w_state_nxt = w_gt ? S_WR_A : S_NEXT;
      end
      S_WR_A: begin
        mem_write   = 1'b1;
        addr        = r_base + {21'd0, r_i};
        din         = r_b;
        w_state_nxt = S_WR_B;
      end
      S_WR_B: begin
        mem_write   = 1'b1;
        addr        = r_base + {21'd0, w_i_inc};
        din         = r_a;
        w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (!w_end_pass) begin
          w_state_nxt = S_RD_A;
        end else if ((w_lim_dec == 11'd0) || w_early_exit) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_A;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // lim counts the compare positions left in the current pass; it shrinks by one per pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= 32'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_i        <= 11'd0;
      r_lim      <= 11'd0;
      r_swap_cnt <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base;
            r_lim      <= w_len_clamped - 11'd1;
            r_i        <= 11'd0;
            r_swap_cnt <= 32'd0;
          end
        end
        S_RD_A: r_a <= read_data;
        S_RD_B: r_b <= read_data;
        S_CMP: begin
          if (w_gt) r_swap_cnt <= r_swap_cnt + 32'd1;
        end
        S_NEXT: begin
          if (!w_end_pass) begin
            r_i <= w_i_inc;
          end else begin
            r_i   <= 11'd0;
            r_lim <= w_lim_dec;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sort_master.sv
// Scoreboard bench for mem_sort_master: directed sorts with hand-computed results and latencies.
// Honours SORT_EARLY_EXIT_EN for the one vector whose latency depends on it.
module tb_mem_sort_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = 32'd0;
  logic [10:0] len = 11'd0;
  logic        busy, done, mem_read, mem_write;
  logic [31:0] swap_cnt, addr, din, read_data;

  logic [31:0] mem [0:1023];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_waddr = 10'd0;
  logic [31:0] tb_wdata = 32'd0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mem_sort_master #(.MAX_LEN(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .swap_cnt(swap_cnt),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .din(din),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = mem[addr[9:0]];

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (mem_write) mem[addr[9:0]] <= din;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               base;
    int               n;
    logic [7:0][31:0] words;
    int               swaps;
    int               lat;
    int               rd;
    int               wr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic push_exp(input int b, input int n, input logic [7:0][31:0] w,
                          input int sw, input int lat, input int rd, input int wr);
    exp_t x;
    x.base = b; x.n = n; x.words = w; x.swaps = sw; x.lat = lat; x.rd = rd; x.wr = wr;
    sb.push_back(x);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each done pulse
  logic prev_busy = 1'b0;
  int   rise_cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      chk("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (!mem_read && !mem_write) chk("addr_zero_when_unused", 64'(addr), 64'd0);
      if (!mem_write) chk("din_zero_when_unused", 64'(din), 64'd0);
      if (busy && !prev_busy) begin
        rise_cyc = cyc;
        rd_cnt = 0;
        wr_cnt = 0;
      end
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (done) begin
        chk("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("swap_cnt", 64'(swap_cnt), 64'(e.swaps));
          chk("latency", 64'(cyc - rise_cyc + 1), 64'(e.lat));
          chk("read_strobes", 64'(rd_cnt), 64'(e.rd));
          chk("write_strobes", 64'(wr_cnt), 64'(e.wr));
          chk("busy_in_done", 64'(busy), 64'd1);
          for (int k = 0; k < e.n; k++)
            chk($sformatf("mem[%0d]", e.base + k), 64'(mem[(e.base + k) % 1024]), 64'(e.words[k]));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wr_mem(input int a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_waddr = 10'(a);
    tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_within_budget", 64'(seen), 64'd1);
  endtask

  task automatic run_sort(input int b, input int l, input int budget);
    @(negedge clk);
    base = 32'(b);
    len = 11'(l);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(budget);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
    chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
    chk({tag, "_din"}, 64'(din), 64'd0);
    chk({tag, "_swap_cnt"}, 64'(swap_cnt), 64'd0);
  endtask

  initial begin
    bit seen_wr;

    #3 chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two words, one swap: 6 work cycles then DONE
    wr_mem(0, 32'd5);
    wr_mem(1, 32'd3);
    push_exp(0, 2, {192'd0, 32'd5, 32'd3}, 1, 7, 2, 2);
    run_sort(0, 2, 50);
    repeat (5) @(negedge clk);
    chk("swap_cnt_hold", 64'(swap_cnt), 64'd1);
    chk("idle_not_busy", 64'(busy), 64'd0);

    // Already sorted: no writes
    for (int k = 0; k < 4; k++) wr_mem(10 + k, 32'(k + 1));
`ifdef SORT_EARLY_EXIT_EN
    push_exp(10, 4, {128'd0, 32'd4, 32'd3, 32'd2, 32'd1}, 0, 13, 6, 0);
`else
    push_exp(10, 4, {128'd0, 32'd4, 32'd3, 32'd2, 32'd1}, 0, 25, 12, 0);
`endif
    run_sort(10, 4, 100);

    // Signed values with duplicates, guarded on both sides
    wr_mem(99, 32'hDEADBEEF);
    wr_mem(100, 32'hFFFFFFFF);
    wr_mem(101, 32'd7);
    wr_mem(102, 32'd0);
    wr_mem(103, 32'hFFFFFFF8);
    wr_mem(104, 32'd7);
    wr_mem(105, 32'hCAFEF00D);
    push_exp(100, 5, {96'd0, 32'd7, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF8}, 4, 49, 20, 8);
    run_sort(100, 5, 200);
    chk("guard_below", 64'(mem[99]), 64'h00000000DEADBEEF);
    chk("guard_above", 64'(mem[105]), 64'h00000000CAFEF00D);

    // Degenerate lengths go straight to DONE
    push_exp(50, 0, 256'd0, 0, 1, 0, 0);
    run_sort(50, 0, 10);
    push_exp(50, 0, 256'd0, 0, 1, 0, 0);
    run_sort(50, 1, 10);

    // Start pulsed while busy must be ignored
    wr_mem(200, 32'd3);
    wr_mem(201, 32'd2);
    wr_mem(202, 32'd1);
    push_exp(200, 3, {160'd0, 32'd3, 32'd2, 32'd1}, 3, 19, 6, 6);
    @(negedge clk);
    base = 32'd200;
    len = 11'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    base = 32'd0;
    len = 11'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    repeat (10) @(negedge clk);

    // Start held high through DONE launches a second sort
    wr_mem(0, 32'd5);
    wr_mem(1, 32'd3);
    push_exp(0, 2, {192'd0, 32'd5, 32'd3}, 1, 7, 2, 2);
    push_exp(0, 2, {192'd0, 32'd5, 32'd3}, 0, 5, 2, 0);
    @(negedge clk);
    base = 32'd0;
    len = 11'd2;
    start = 1'b1;
    wait_done(50);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(50);
    repeat (3) @(negedge clk);

    // Asynchronous reset during the first WR_A of a length-8 sort
    for (int k = 0; k < 8; k++) wr_mem(300 + k, 32'(8 - k));
    @(negedge clk);
    base = 32'd300;
    len = 11'd8;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen_wr = 1'b0;
    for (int k = 0; k < 200 && !seen_wr; k++) begin
      @(negedge clk);
      seen_wr = mem_write;
    end
    chk("wr_a_reached", 64'(seen_wr), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) wr_mem(300 + k, 32'(8 - k));
    push_exp(300, 8, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 28, 169, 56, 56);
    run_sort(300, 8, 400);
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
